side_by_side_merge: RTL

Re-assembles a side-by-side stereo video line from two synchronous half-width pixel streams, left and right, carried on one shared DE/HSYNC/VSYNC timing. It is the inverse of the stereo split stage and feeds the HDMI output path. Left pixels are forwarded with one cycle of latency. Right pixels are held in a one-line buffer and replayed immediately after the left half, so each output line carries `2*HALF_IMG_W` contiguous active pixels.

---
 rtl/sgm_video_pkg.sv | 30 +++
 rtl/line_buffer_ram.sv | 41 ++++
 rtl/side_by_side_merge.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sgm_video_pkg.sv
// Shared definitions for the stereo video merge path.
//
// Contents:
//   PIXEL_W        - default pixel width (3 x 8-bit R,G,B)
//   merge_state_t  - states of the side-by-side merge FSM
//   clog2          - ceiling log2 usable in parameter expressions
package sgm_video_pkg;

    localparam int PIXEL_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEFT,
        ST_RIGHT
    } merge_state_t;

    // Number of bits needed to index 'value' distinct entries.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// One-line pixel store for the right half of a stereo line.
//
// Simple dual-port RAM with one write port and one registered read port,
// no reset, written so that synthesis maps it onto block RAM.
//
// Ports:
//   clk      - clock for both ports
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_en    - read strobe; rd_data updates on the following edge
//   rd_addr  - read address
//   rd_data  - registered read data (holds its value while rd_en is low)
module line_buffer_ram
    import sgm_video_pkg::*;
#(
    parameter int DEPTH = 400,
    parameter int WIDTH = 24,
    localparam int ADDR_W = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/side_by_side_merge.sv
// Side-by-side stereo line merge.
//
// Takes left and right half-width pixel streams that share one DE/HSYNC/
// VSYNC timing and produces a single full-width line: the left half is
// forwarded with one cycle of latency, the right half is stored in a line
// buffer and replayed immediately after the left half.
//
// Ports:
//   clk          - pixel clock
//   rst          - asynchronous active-high reset
//   de_in        - data enable, both input pixels valid
//   h_sync_in    - horizontal sync, delayed by one cycle to h_sync_out
//   v_sync_in    - vertical sync, delayed by one cycle to v_sync_out
//   pixel_left   - left-half pixel
//   pixel_right  - right-half pixel at the same column
//   de_out       - merged data enable
//   h_sync_out   - delayed horizontal sync
//   v_sync_out   - delayed vertical sync
//   pixel_out    - merged pixel, zero whenever de_out is low
//   overrun      - sticky: line too long or too little blanking
module side_by_side_merge
    import sgm_video_pkg::*;
#(
    parameter int HALF_IMG_W = 400,
    parameter int PIXEL_W    = sgm_video_pkg::PIXEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               de_in,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    input  logic [PIXEL_W-1:0] pixel_left,
    input  logic [PIXEL_W-1:0] pixel_right,
    output logic               de_out,
    output logic               h_sync_out,
    output logic               v_sync_out,
    output logic [PIXEL_W-1:0] pixel_out,
    output logic               overrun
);

    localparam int CW = clog2(HALF_IMG_W + 1);
    localparam int AW = clog2(HALF_IMG_W);
    localparam logic [CW-1:0] HALF_C = CW'(HALF_IMG_W);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    merge_state_t state, state_next;
    logic [CW-1:0] col, col_next;
    logic [CW-1:0] nright, nright_next;
    logic [CW-1:0] rd_ptr, rd_ptr_next;

    logic               take_left;
    logic               set_overrun;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [PIXEL_W-1:0] rd_data;

    logic [PIXEL_W-1:0] left_q;
    logic               sel_right_q;

    line_buffer_ram #(
        .DEPTH (HALF_IMG_W),
        .WIDTH (PIXEL_W)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (pixel_right),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            col    <= '0;
            nright <= '0;
            rd_ptr <= '0;
        end else begin
            state  <= state_next;
            col    <= col_next;
            nright <= nright_next;
            rd_ptr <= rd_ptr_next;
        end
    end

    // The first active cycle of a line is consumed as left pixel 0 in the
    // same cycle it is seen, both from IDLE and when a new line cuts a
    // right-half replay short, so left latency stays at exactly one cycle.
    always_comb begin
        state_next  = state;
        col_next    = col;
        nright_next = nright;
        rd_ptr_next = rd_ptr;
        take_left   = 1'b0;
        set_overrun = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = col[AW-1:0];
        rd_en       = 1'b0;
        rd_addr     = rd_ptr[AW-1:0];

        case (state)
            ST_IDLE: begin
                if (de_in) begin
                    take_left  = 1'b1;
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    col_next   = ONE_C;
                    state_next = ST_LEFT;
                end
            end

            ST_LEFT: begin
                if (de_in) begin
                    if (col < HALF_C) begin
                        take_left = 1'b1;
                        wr_en     = 1'b1;
                        col_next  = col + ONE_C;
                    end else begin
                        set_overrun = 1'b1;
                    end
                end else if (col == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    // Address 0 is read on the falling-DE cycle so the right
                    // half follows the last left pixel with no gap; a
                    // one-pixel line is then already fully scheduled.
                    nright_next = col;
                    rd_en       = 1'b1;
                    rd_addr     = '0;
                    rd_ptr_next = ONE_C;
                    state_next  = (col == ONE_C) ? ST_IDLE : ST_RIGHT;
                end
            end

            ST_RIGHT: begin
                if (de_in) begin
                    set_overrun = 1'b1;
                    take_left   = 1'b1;
                    wr_en       = 1'b1;
                    wr_addr     = '0;
                    col_next    = ONE_C;
                    state_next  = ST_LEFT;
                end else begin
                    rd_en       = 1'b1;
                    rd_ptr_next = rd_ptr + ONE_C;
                    if (rd_ptr == nright - ONE_C) begin
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output registers. A right pixel is the registered RAM output itself,
    // so only the select flag is registered here; left_q is forced to zero
    // when no left pixel is emitted so the output mux yields zero in blanking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_out      <= 1'b0;
            h_sync_out  <= 1'b0;
            v_sync_out  <= 1'b0;
            overrun     <= 1'b0;
            left_q      <= '0;
            sel_right_q <= 1'b0;
        end else begin
            de_out      <= take_left | rd_en;
            h_sync_out  <= h_sync_in;
            v_sync_out  <= v_sync_in;
            overrun     <= overrun | set_overrun;
            left_q      <= take_left ? pixel_left : '0;
            sel_right_q <= rd_en;
        end
    end

    assign pixel_out = sel_right_q ? rd_data : left_q;

endmodule
